// File: rtl/avalon_pkg.sv
// Shared definitions for the Avalon-style responder.
// Holds the FSM state type, default parameter values and the 16-bit word type.
package avalon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int WAIT_STATES_DEF = 2;
    localparam int ADDR_BITS_DEF   = 8;

    typedef logic [15:0] word_t;

endpackage

// File: rtl/avalon_resp_mem.sv
// Single-port word store for avalon_responder.
// Ports:
//   clk      - rising-edge clock
//   addr     - word address, shared by read and write
//   wr_en    - write strobe, wr_data written to addr on the rising edge
//   wr_data  - write data
//   rd_en    - read strobe, rd_data loaded from addr on the rising edge
//   rd_data  - registered read data, holds when rd_en is low
// No reset: contents are undefined until written.
module avalon_resp_mem
    import avalon_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 wr_en,
    input  word_t                wr_data,
    input  logic                 rd_en,
    output word_t                rd_data
);

    word_t mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/avalon_responder.sv
// Avalon-style memory responder with programmable wait states.
// Ports:
//   Clock      - rising-edge system clock
//   Resetn     - asynchronous active-low reset
//   ReadData   - read request strobe
//   WriteData  - write request strobe
//   DataAddr   - word address, only [ADDR_BITS-1:0] decoded (store aliases)
//   DataOut    - write data from initiator
//   DataIn     - read data to initiator, valid in ACK, held until next read
//   Waitreq    - stall, high while a request is present and not in ACK
//   ErrFlag    - sticky protocol-violation flag (both strobes, or abort)
//
// state | meaning
// IDLE  | no transfer in flight; a request starts one
// WAIT  | counting stall cycles down to zero
// ACK   | transfer completes this cycle (write commits at its end)
module avalon_responder
    import avalon_pkg::*;
#(
    parameter int WAIT_STATES = WAIT_STATES_DEF,
    parameter int ADDR_BITS   = ADDR_BITS_DEF
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        ReadData,
    input  logic        WriteData,
    input  logic [15:0] DataAddr,
    input  logic [15:0] DataOut,
    output logic [15:0] DataIn,
    output logic        Waitreq,
    output logic        ErrFlag
);

    localparam bit         NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        rd_seen;
    logic        req;
    logic        both;
    logic        enter_ack;
    logic        abort;
    logic        rd_load;
    logic        wr_commit;
    word_t       mem_q;

    assign req  = ReadData | WriteData;
    assign both = ReadData & WriteData;

    assign enter_ack = req && (((state == IDLE) && NO_WAIT) ||
                               ((state == WAIT) && (cnt == 4'd0)));
    assign abort     = (state == WAIT) && !req;

    // Simultaneous strobes are treated as a write, so only a pure read loads DataIn.
    assign rd_load   = enter_ack && ReadData && !WriteData;
    assign wr_commit = (state == ACK) && WriteData;

    assign Waitreq = req && (state != ACK);

    avalon_resp_mem #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk     (Clock),
        .addr    (DataAddr[ADDR_BITS-1:0]),
        .wr_en   (wr_commit),
        .wr_data (DataOut),
        .rd_en   (rd_load),
        .rd_data (mem_q)
    );

    // The store has no reset, so its read register is masked until the first
    // read completes; this gives DataIn an immediate async clear to zero.
    assign DataIn = rd_seen ? mem_q : 16'h0000;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ErrFlag <= 1'b0;
            rd_seen <= 1'b0;
        end else begin
            if (rd_load) begin
                rd_seen <= 1'b1;
            end
            if ((enter_ack && both) || abort) begin
                ErrFlag <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        if (NO_WAIT) begin
                            state <= ACK;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd0) begin
                        state <= ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_responder.sv
module tb_avalon_responder;

    logic        clk;
    logic        rst_n;

    logic        rd, wr;
    logic [15:0] addr, dout;
    logic [15:0] din;
    logic        waitreq, err;

    logic        rd0, wr0;
    logic [15:0] addr0, dout0;
    logic [15:0] din0;
    logic        waitreq0, err0;

    int vectors;
    int miscompares;

    avalon_responder #(.WAIT_STATES(2), .ADDR_BITS(8)) dut (
        .Clock     (clk),
        .Resetn    (rst_n),
        .ReadData  (rd),
        .WriteData (wr),
        .DataAddr  (addr),
        .DataOut   (dout),
        .DataIn    (din),
        .Waitreq   (waitreq),
        .ErrFlag   (err)
    );

    avalon_responder #(.WAIT_STATES(0), .ADDR_BITS(8)) dut0 (
        .Clock     (clk),
        .Resetn    (rst_n),
        .ReadData  (rd0),
        .WriteData (wr0),
        .DataAddr  (addr0),
        .DataOut   (dout0),
        .DataIn    (din0),
        .Waitreq   (waitreq0),
        .ErrFlag   (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count Waitreq-high cycles until ACK; returns at the negedge inside ACK.
    task automatic wait_ack(output int hi, output logic [15:0] q);
        bit done;
        done = 0;
        hi = 0;
        q = 16'hxxxx;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (waitreq) hi++;
            else begin q = din; done = 1; end
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL ack_timeout: no ACK within 40 cycles");
        end
    endtask

    task automatic xfer(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, output int hi, output logic [15:0] q);
        @(posedge clk); #1;
        rd = r; wr = w; addr = a; dout = d;
        wait_ack(hi, q);
    endtask

    task automatic end_req();
        @(posedge clk); #1;
        rd = 0; wr = 0;
        @(negedge clk);
    endtask

    task automatic xfer0(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d, output int hi, output logic [15:0] q);
        bit done;
        @(posedge clk); #1;
        rd0 = r; wr0 = w; addr0 = a; dout0 = d;
        done = 0; hi = 0; q = 16'hxxxx;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (waitreq0) hi++;
            else begin q = din0; done = 1; end
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL ack0_timeout: no ACK within 40 cycles");
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        vectors++; if (din !== 16'h0000) begin miscompares++; $display("FAIL reset_din: got %h want 0000", din); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
        vectors++; if (waitreq !== 1'b0) begin miscompares++; $display("FAIL reset_waitreq: got %b want 0", waitreq); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_write_read();
        int hi; logic [15:0] q;
        xfer(0, 1, 16'h0012, 16'hBEEF, hi, q);
        vectors++; if (hi !== 3) begin miscompares++; $display("FAIL wr_wait_cycles: got %0d want 3", hi); end
        end_req();
        vectors++; if (waitreq !== 1'b0) begin miscompares++; $display("FAIL idle_waitreq: got %b want 0", waitreq); end
        xfer(1, 0, 16'h0012, 16'h0000, hi, q);
        vectors++; if (hi !== 3) begin miscompares++; $display("FAIL rd_wait_cycles: got %0d want 3", hi); end
        vectors++; if (q !== 16'hBEEF) begin miscompares++; $display("FAIL rd_beef: got %h want BEEF", q); end
        end_req();
        vectors++; if (din !== 16'hBEEF) begin miscompares++; $display("FAIL din_hold: got %h want BEEF", din); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_clean: got %b want 0", err); end
    endtask

    task automatic test_alias();
        int hi; logic [15:0] q;
        xfer(0, 1, 16'h0105, 16'h1234, hi, q);
        end_req();
        xfer(1, 0, 16'h0005, 16'h0000, hi, q);
        vectors++; if (q !== 16'h1234) begin miscompares++; $display("FAIL alias_read: got %h want 1234", q); end
        end_req();
    endtask

    task automatic test_both();
        int hi; logic [15:0] q;
        xfer(1, 1, 16'h0020, 16'hAAAA, hi, q);
        vectors++; if (q !== 16'h1234) begin miscompares++; $display("FAIL both_din_kept: got %h want 1234", q); end
        end_req();
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL both_err: got %b want 1", err); end
        xfer(1, 0, 16'h0020, 16'h0000, hi, q);
        vectors++; if (q !== 16'hAAAA) begin miscompares++; $display("FAIL both_written: got %h want AAAA", q); end
        end_req();
    endtask

    task automatic test_abort();
        int hi; logic [15:0] q;
        test_reset();
        xfer(0, 1, 16'h0030, 16'h1111, hi, q);
        end_req();
        @(posedge clk); #1;
        wr = 1; addr = 16'h0030; dout = 16'h5555;
        @(negedge clk);
        @(negedge clk);
        wr = 0;
        @(negedge clk);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL abort_err: got %b want 1", err); end
        vectors++; if (waitreq !== 1'b0) begin miscompares++; $display("FAIL abort_waitreq: got %b want 0", waitreq); end
        xfer(1, 0, 16'h0030, 16'h0000, hi, q);
        vectors++; if (q !== 16'h1111) begin miscompares++; $display("FAIL abort_no_write: got %h want 1111", q); end
        end_req();
    endtask

    task automatic test_reset_mid();
        int hi; logic [15:0] q;
        xfer(0, 1, 16'h0040, 16'h2222, hi, q);
        end_req();
        xfer(1, 0, 16'h0040, 16'h0000, hi, q);
        end_req();
        @(posedge clk); #1;
        wr = 1; addr = 16'h0040; dout = 16'h7777;
        @(negedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        vectors++; if (din !== 16'h0000) begin miscompares++; $display("FAIL midrst_din: got %h want 0000", din); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %b want 0", err); end
        wr = 0; rd = 1; addr = 16'h0040;
        @(posedge clk); #1;
        rst_n = 1;
        wait_ack(hi, q);
        vectors++; if (hi !== 3) begin miscompares++; $display("FAIL rst_release_latency: got %0d want 3", hi); end
        vectors++; if (q !== 16'h2222) begin miscompares++; $display("FAIL midrst_no_write: got %h want 2222", q); end
        end_req();
    endtask

    task automatic test_back_to_back();
        int hi; logic [15:0] q;
        xfer0(0, 1, 16'h0001, 16'hCAFE, hi, q);
        vectors++; if (hi !== 1) begin miscompares++; $display("FAIL b2b_wr_wait: got %0d want 1", hi); end
        xfer0(1, 0, 16'h0001, 16'h0000, hi, q);
        vectors++; if (hi !== 1) begin miscompares++; $display("FAIL b2b_rd_wait: got %0d want 1", hi); end
        vectors++; if (q !== 16'hCAFE) begin miscompares++; $display("FAIL b2b_rd_data: got %h want CAFE", q); end
        @(posedge clk); #1;
        rd0 = 0; wr0 = 0;
        @(negedge clk);
        vectors++; if (err0 !== 1'b0) begin miscompares++; $display("FAIL b2b_err: got %b want 0", err0); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rd = 0; wr = 0; addr = 0; dout = 0;
        rd0 = 0; wr0 = 0; addr0 = 0; dout0 = 0;
        rst_n = 1;
        test_reset();
        test_write_read();
        test_alias();
        test_both();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
